// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding, word-offset constant and alignment helper for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int WORD_LSB = 2;

    function automatic logic addr_misaligned(input logic [WORD_LSB-1:0] byte_offset);
        return byte_offset != '0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array with synchronous write and combinational read; contents survive reset
module dmem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - CPU data-memory responder with wait-state FSM and core stall (hazard) generation
// Optional rd_cnt/wr_cnt access counters are built when DMEM_PERF_CNT_EN is defined.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2      = 10,
    parameter int WAIT_CYCLES     = 2
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_raddr,
    input  logic                       cpu_data_mem_read,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_waddr,
    input  logic [DATA_WIDTH-1:0]      cpu_data_mem_wdata,
    input  logic                       cpu_data_mem_write,
    output logic [DATA_WIDTH-1:0]      data_mem_rdata,
    output logic                       data_mem_hazard,
    output logic                       misalign_err
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0]                rd_cnt,
    output logic [31:0]                wr_cnt
`endif
);

    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                       req;
    logic                       acc_is_wr;
    logic                       acc_mis;
    logic                       acc_ok;
    logic [DATA_ADDR_WIDTH-1:0] acc_addr;
    logic [DEPTH_LOG2-1:0]      idx_in;

    dmem_state_e                state_q;
    logic [CNT_W-1:0]           cnt_q;
    logic                       op_wr_q;
    logic [DEPTH_LOG2-1:0]      idx_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic                       mis_q;

    logic                       from_idle;
    logic                       accept;
    logic                       enter_resp;
    logic                       cur_wr;
    logic [DEPTH_LOG2-1:0]      cur_idx;
    logic [DATA_WIDTH-1:0]      cur_wdata;
    logic                       mem_we;
    logic [DATA_WIDTH-1:0]      mem_rd;
    logic                       unused_addr_bits;

    // A simultaneous read+write is a write, so the write address selects the word.
    assign req       = cpu_data_mem_read | cpu_data_mem_write;
    assign acc_is_wr = cpu_data_mem_write;
    assign acc_addr  = acc_is_wr ? cpu_data_mem_waddr : cpu_data_mem_raddr;
    assign acc_mis   = req & addr_misaligned(acc_addr[WORD_LSB-1:0]);
    assign acc_ok    = req & ~acc_mis;
    assign idx_in    = acc_addr[DEPTH_LOG2+WORD_LSB-1:WORD_LSB];

    assign unused_addr_bits = ^{cpu_data_mem_raddr, cpu_data_mem_waddr};

    assign from_idle  = (state_q == IDLE);
    assign accept     = !ZERO_WAIT && from_idle && acc_ok;
    assign enter_resp = (accept && CNT_LOAD == '0) || (state_q == WAIT && cnt_q == CNT_ONE);

    // With a single wait state RESP is entered straight from IDLE, so the live request is used.
    assign cur_wr    = from_idle ? acc_is_wr : op_wr_q;
    assign cur_idx   = from_idle ? idx_in : idx_q;
    assign cur_wdata = from_idle ? cpu_data_mem_wdata : wdata_q;

    assign mem_we = !cpu_rst && (ZERO_WAIT ? (acc_ok && acc_is_wr) : (enter_resp && cur_wr));

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk_i   (cpu_clk),
        .we_i    (mem_we),
        .waddr_i (cur_idx),
        .wdata_i (cur_wdata),
        .raddr_i (cur_idx),
        .rdata_o (mem_rd)
    );

    assign data_mem_hazard = accept || (state_q == WAIT);
    assign misalign_err    = mis_q;

    always_comb begin
        data_mem_rdata = '0;
        if (ZERO_WAIT) begin
            if (acc_ok && !acc_is_wr) begin
                data_mem_rdata = mem_rd;
            end
        end else if (state_q == RESP && !op_wr_q) begin
            data_mem_rdata = rdata_q;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            if (from_idle && acc_mis) begin
                mis_q <= 1'b1;
            end
            if (enter_resp && !cur_wr) begin
                rdata_q <= mem_rd;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_wr_q <= acc_is_wr;
                        idx_q   <= idx_in;
                        wdata_q <= cpu_data_mem_wdata;
                        cnt_q   <= CNT_LOAD;
                        state_q <= (CNT_LOAD == '0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_PERF_CNT_EN
    logic        rd_inc;
    logic        wr_inc;
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    assign rd_inc = ZERO_WAIT ? (acc_ok && !acc_is_wr) : (enter_resp && !cur_wr);
    assign wr_inc = ZERO_WAIT ? (acc_ok && acc_is_wr) : (enter_resp && cur_wr);

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_inc && rd_cnt_q != '1) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (wr_inc && wr_cnt_q != '1) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench over four responders with WAIT_CYCLES 2, 1, 4 and 0
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst [4];
    logic        rd  [4];
    logic        wr  [4];
    logic [31:0] ra  [4];
    logic [31:0] wa  [4];
    logic [31:0] wd  [4];
    logic [31:0] rdata_w [4];
    logic        hz_w    [4];
    logic        mis_w   [4];
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rdc_w [4];
    logic [31:0] wrc_w [4];
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int WC = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 0;
        data_mem_responder #(
            .DATA_WIDTH      (32),
            .DATA_ADDR_WIDTH (32),
            .DEPTH_LOG2      (10),
            .WAIT_CYCLES     (WC)
        ) u_dut (
            .cpu_clk            (clk),
            .cpu_rst            (rst[g]),
            .cpu_data_mem_raddr (ra[g]),
            .cpu_data_mem_read  (rd[g]),
            .cpu_data_mem_waddr (wa[g]),
            .cpu_data_mem_wdata (wd[g]),
            .cpu_data_mem_write (wr[g]),
            .data_mem_rdata     (rdata_w[g]),
            .data_mem_hazard    (hz_w[g]),
            .misalign_err       (mis_w[g])
`ifdef DMEM_PERF_CNT_EN
            ,
            .rd_cnt             (rdc_w[g]),
            .wr_cnt             (wrc_w[g])
`endif
        );
    end

    // Holds the request until the hazard-free cycle and reports what happened there.
    task automatic do_access(input int d, input bit r, input bit w, input logic [31:0] addr,
                             input logic [31:0] data, output int hz, output logic [31:0] resp,
                             output int stray);
        bit done;
        @(posedge clk); #1;
        rd[d] = r; wr[d] = w; ra[d] = addr; wa[d] = addr; wd[d] = data;
        hz = 0; stray = 0; resp = 'x; done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (hz_w[d] === 1'b0) begin
                resp = rdata_w[d];
                done = 1'b1;
            end else begin
                hz++;
                if (rdata_w[d] !== 32'h0) stray++;
                @(posedge clk); #1;
            end
        end
        if (!done) hz = -1;
    endtask

    task automatic go_idle(input int d);
        @(posedge clk); #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 4; d++) begin
            rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; ra[d] = '0; wa[d] = '0; wd[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (hz_w[d] !== 1'b0) begin n_fail++; $display("FAIL reset_hazard[%0d]: got %b expected 0", d, hz_w[d]); end
            n_checks++;
            if (rdata_w[d] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 0", d, rdata_w[d]); end
            n_checks++;
            if (mis_w[d] !== 1'b0) begin n_fail++; $display("FAIL reset_misalign[%0d]: got %b expected 0", d, mis_w[d]); end
        end
    endtask

    task automatic test_write_read();
        int hz, stray; logic [31:0] resp, exp;
        sb.push_back(32'h0);
        do_access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, hz, resp, stray);
        exp = sb.pop_front();
        n_checks++;
        if (hz !== 2) begin n_fail++; $display("FAIL wr_hazard_cycles: got %0d expected 2", hz); end
        n_checks++;
        if (resp !== exp) begin n_fail++; $display("FAIL wr_resp_rdata: got %h expected %h", resp, exp); end
        sb.push_back(32'hDEADBEEF);
        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, hz, resp, stray);
        exp = sb.pop_front();
        n_checks++;
        if (hz !== 2) begin n_fail++; $display("FAIL rd_hazard_cycles: got %0d expected 2", hz); end
        n_checks++;
        if (resp !== exp) begin n_fail++; $display("FAIL rd_resp_rdata: got %h expected %h", resp, exp); end
        n_checks++;
        if (stray !== 0) begin n_fail++; $display("FAIL rd_rdata_during_hazard: got %0d nonzero cycles expected 0", stray); end
        go_idle(0);
        @(negedge clk);
        n_checks++;
        if (rdata_w[0] !== 32'h0) begin n_fail++; $display("FAIL rdata_after_resp: got %h expected 0", rdata_w[0]); end
    endtask

    task automatic test_back_to_back();
        int hz, stray; logic [31:0] resp, exp;
        sb.push_back(32'h0);
        do_access(1, 1'b0, 1'b1, 32'h0, 32'h1, hz, resp, stray);
        exp = sb.pop_front();
        n_checks++;
        if (hz !== 1) begin n_fail++; $display("FAIL b2b_wr_hazard: got %0d expected 1", hz); end
        n_checks++;
        if (resp !== exp) begin n_fail++; $display("FAIL b2b_wr_rdata: got %h expected %h", resp, exp); end
        sb.push_back(32'h1);
        do_access(1, 1'b1, 1'b0, 32'h0, 32'h0, hz, resp, stray);
        exp = sb.pop_front();
        n_checks++;
        if (hz !== 1) begin n_fail++; $display("FAIL b2b_rd_hazard: got %0d expected 1", hz); end
        n_checks++;
        if (resp !== exp) begin n_fail++; $display("FAIL b2b_rd_rdata: got %h expected %h", resp, exp); end
        go_idle(1);
        @(negedge clk);
        n_checks++;
        if (hz_w[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_no_duplicate: hazard got %b expected 0", hz_w[1]); end
`ifdef DMEM_PERF_CNT_EN
        n_checks++;
        if (wrc_w[1] !== 32'd1) begin n_fail++; $display("FAIL b2b_wr_cnt: got %0d expected 1", wrc_w[1]); end
        n_checks++;
        if (rdc_w[1] !== 32'd1) begin n_fail++; $display("FAIL b2b_rd_cnt: got %0d expected 1", rdc_w[1]); end
`endif
    endtask

    task automatic test_misaligned();
        int hz, stray; logic [31:0] resp, exp;
        sb.push_back(32'h0);
        do_access(0, 1'b1, 1'b0, 32'h13, 32'h0, hz, resp, stray);
        exp = sb.pop_front();
        n_checks++;
        if (hz !== 0) begin n_fail++; $display("FAIL mis_hazard: got %0d expected 0", hz); end
        n_checks++;
        if (resp !== exp) begin n_fail++; $display("FAIL mis_rdata: got %h expected %h", resp, exp); end
        go_idle(0);
        @(negedge clk);
        n_checks++;
        if (mis_w[0] !== 1'b1) begin n_fail++; $display("FAIL mis_flag_set: got %b expected 1", mis_w[0]); end
        sb.push_back(32'hDEADBEEF);
        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, hz, resp, stray);
        exp = sb.pop_front();
        n_checks++;
        if (hz !== 2 || resp !== exp) begin
            n_fail++; $display("FAIL mis_then_aligned: got hz=%0d rdata=%h expected hz=2 rdata=%h", hz, resp, exp);
        end
        n_checks++;
        if (mis_w[0] !== 1'b1) begin n_fail++; $display("FAIL mis_flag_sticky: got %b expected 1", mis_w[0]); end
    endtask

    task automatic test_wrap_simultaneous();
        int hz, stray; logic [31:0] resp, exp;
        sb.push_back(32'h0);
        do_access(0, 1'b1, 1'b1, 32'h1000, 32'hA5A5A5A5, hz, resp, stray);
        exp = sb.pop_front();
        n_checks++;
        if (hz !== 2 || resp !== exp) begin
            n_fail++; $display("FAIL wrap_both_req: got hz=%0d rdata=%h expected hz=2 rdata=%h", hz, resp, exp);
        end
        sb.push_back(32'hA5A5A5A5);
        do_access(0, 1'b1, 1'b0, 32'h0, 32'h0, hz, resp, stray);
        exp = sb.pop_front();
        n_checks++;
        if (resp !== exp) begin n_fail++; $display("FAIL wrap_read0: got %h expected %h", resp, exp); end
        go_idle(0);
    endtask

    task automatic test_reset_mid_access();
        int hz, stray; logic [31:0] resp, exp;
        do_access(2, 1'b0, 1'b1, 32'h20, 32'h11, hz, resp, stray);
        n_checks++;
        if (hz !== 4) begin n_fail++; $display("FAIL rst_prewrite_hazard: got %0d expected 4", hz); end
        @(posedge clk); #1;
        wd[2] = 32'h55;
        @(negedge clk);
        n_checks++;
        if (hz_w[2] !== 1'b1) begin n_fail++; $display("FAIL rst_hazard_start: got %b expected 1", hz_w[2]); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[2] = 1'b1; wr[2] = 1'b0;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hz_w[2] !== 1'b0) begin n_fail++; $display("FAIL rst_hazard_drop: got %b expected 0", hz_w[2]); end
        sb.push_back(32'h11);
        do_access(2, 1'b1, 1'b0, 32'h20, 32'h0, hz, resp, stray);
        exp = sb.pop_front();
        n_checks++;
        if (hz !== 4 || resp !== exp) begin
            n_fail++; $display("FAIL rst_write_discarded: got hz=%0d rdata=%h expected hz=4 rdata=%h", hz, resp, exp);
        end
        go_idle(2);
    endtask

    task automatic test_zero_wait();
        int hz, stray; logic [31:0] resp, exp;
        sb.push_back(32'h0);
        do_access(3, 1'b0, 1'b1, 32'h8, 32'h77, hz, resp, stray);
        exp = sb.pop_front();
        n_checks++;
        if (hz !== 0 || resp !== exp) begin
            n_fail++; $display("FAIL zw_write: got hz=%0d rdata=%h expected hz=0 rdata=%h", hz, resp, exp);
        end
        sb.push_back(32'h77);
        do_access(3, 1'b1, 1'b0, 32'h8, 32'h0, hz, resp, stray);
        exp = sb.pop_front();
        n_checks++;
        if (hz !== 0) begin n_fail++; $display("FAIL zw_read_hazard: got %0d expected 0", hz); end
        n_checks++;
        if (resp !== exp) begin n_fail++; $display("FAIL zw_read_rdata: got %h expected %h", resp, exp); end
        go_idle(3);
        @(negedge clk);
        n_checks++;
        if (rdata_w[3] !== 32'h0) begin n_fail++; $display("FAIL zw_idle_rdata: got %h expected 0", rdata_w[3]); end
`ifdef DMEM_PERF_CNT_EN
        n_checks++;
        if (wrc_w[3] !== 32'd1) begin n_fail++; $display("FAIL zw_wr_cnt: got %0d expected 1", wrc_w[3]); end
        n_checks++;
        if (rdc_w[3] !== 32'd1) begin n_fail++; $display("FAIL zw_rd_cnt: got %0d expected 1", rdc_w[3]); end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_misaligned();
        test_wrap_simultaneous();
        test_reset_mid_access();
        test_zero_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
